// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and types for the MEM stage: access-size encodings,
// bypass-bus width and the latched instruction fields.
package mem_stage_lsu_pkg;

  localparam logic [1:0] MEM_B = 2'b01;
  localparam logic [1:0] MEM_H = 2'b10;
  localparam logic [1:0] MEM_W = 2'b11;

  localparam int MEM_TO_ID_WD = 40;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        regw;
    logic [4:0]  regw_addr;
    logic        res_from_mem;
    logic        memw;
    logic [1:0]  mem_size;
    logic        load_sign;
    logic        excp;
    logic        ertn;
  } mem_fields_t;

  // Extend a byte or half lane to 32 bits, signed or unsigned.
  function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                              input logic        is_half,
                                              input logic        sign);
    logic msb;
    msb = is_half ? lane[15] : lane[7];
    if (is_half) return {{16{sign & msb}}, lane};
    return {{24{sign & msb}}, lane[7:0]};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: picks the byte/half lane addressed by the low address
// bits and extends it; word loads pass through unchanged.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output of a combinational block gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    result = rdata;
    unique case (size)
      MEM_B:   result = extend_lane({8'h00, byte_lane}, 1'b0, sign);
      MEM_H:   result = extend_lane(half_lane, 1'b1, sign);
      MEM_W:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one instruction, waits for the data-bus response
// of its load/store, aligns load data, and absorbs responses of flushed requests.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    exe_to_mem_valid,
  output logic                    mem_allowin,
  input  logic [31:0]             exe_pc,
  input  logic [31:0]             exe_result,
  input  logic                    exe_regW,
  input  logic [4:0]              exe_regWAddr,
  input  logic                    exe_res_from_mem,
  input  logic                    exe_memW,
  input  logic [1:0]              exe_memINS_rec,
  input  logic                    exe_load_sign,
  input  logic                    exe_excp,
  input  logic                    exe_ertn,

  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,

  input  logic                    wb_allowin,
  output logic                    mem_to_wb_valid,
  output logic [31:0]             mem_to_wb_pc,
  output logic [31:0]             mem_to_wb_result,
  output logic                    mem_to_wb_regW,
  output logic [4:0]              mem_to_wb_regWAddr,
  output logic                    mem_to_wb_excp,
  output logic                    mem_to_wb_ertn,

  input  logic                    wb_flush,
  output logic                    mem_to_exe_flush_excp_ertn,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  mem_fields_t         fields_q, fields_d;
  logic                mem_valid_q;
  logic                rdata_buf_valid_q;
  logic [31:0]         rdata_buf_q;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

  logic        mem_wait;
  logic        data_ok_hit;
  logic        mem_ready_go;
  logic        cancel_inc;
  logic        cancel_dec;
  logic        buf_set;
  logic        buf_clr;
  logic [31:0] load_rdata;
  logic [31:0] load_data;

  assign fields_d = '{
    pc:           exe_pc,
    result:       exe_result,
    regw:         exe_regW,
    regw_addr:    exe_regWAddr,
    res_from_mem: exe_res_from_mem,
    memw:         exe_memW,
    mem_size:     exe_memINS_rec,
    load_sign:    exe_load_sign,
    excp:         exe_excp,
    ertn:         exe_ertn
  };

  // Excepting or ERTN instructions never issued a bus request, so never wait.
  assign mem_wait     = (fields_q.res_from_mem | fields_q.memw) & ~fields_q.excp & ~fields_q.ertn;
  assign data_ok_hit  = data_sram_data_ok & (cancel_cnt_q == '0);
  assign mem_ready_go = ~mem_wait | data_ok_hit | rdata_buf_valid_q;
  assign mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);

  assign mem_to_wb_valid = mem_valid_q & mem_ready_go;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
    end else if (wb_flush) begin
      mem_valid_q <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid_q <= exe_to_mem_valid;
    end
  end

  // NOTE: the field and buffer registers are datapath, but they are reset
  // anyway so the outputs are defined (all zero) straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fields_q <= '0;
    end else if (mem_allowin & exe_to_mem_valid) begin
      fields_q <= fields_d;
    end
  end

  // Park a response that arrives while WB is stalled, so it is not lost.
  assign buf_set = data_ok_hit & mem_valid_q & mem_wait & ~wb_allowin;
  assign buf_clr = (mem_to_wb_valid & wb_allowin) | wb_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf_valid_q <= 1'b0;
      rdata_buf_q       <= '0;
    end else if (buf_clr) begin
      rdata_buf_valid_q <= 1'b0;
    end else if (buf_set) begin
      rdata_buf_valid_q <= 1'b1;
      rdata_buf_q       <= data_sram_rdata;
    end
  end

  // A flush orphans the pending request; count it so its response is dropped.
  assign cancel_inc = wb_flush & mem_valid_q & mem_wait & ~data_ok_hit & ~rdata_buf_valid_q;
  assign cancel_dec = data_sram_data_ok & (cancel_cnt_q != '0);

  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (cancel_inc & ~cancel_dec) begin
      cancel_cnt_d = cancel_cnt_q + CANCEL_W'(1);
    end else if (cancel_dec & ~cancel_inc) begin
      cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_cnt_q <= '0;
    end else begin
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  cancel_cnt_no_overflow : assert property (
    @(posedge clk) disable iff (!resetn)
      !(cancel_inc && !cancel_dec && (cancel_cnt_q == {CANCEL_W{1'b1}}))
  );

  assign load_rdata = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

  mem_stage_lsu_load_align u_load_align (
    .rdata  (load_rdata),
    .addr   (fields_q.result[1:0]),
    .size   (fields_q.mem_size),
    .sign   (fields_q.load_sign),
    .result (load_data)
  );

  assign mem_to_wb_pc       = fields_q.pc;
  assign mem_to_wb_result   = fields_q.res_from_mem ? load_data : fields_q.result;
  assign mem_to_wb_regW     = fields_q.regw & ~fields_q.excp;
  assign mem_to_wb_regWAddr = fields_q.regw_addr;
  assign mem_to_wb_excp     = fields_q.excp;
  assign mem_to_wb_ertn     = fields_q.ertn;

  assign mem_to_exe_flush_excp_ertn = wb_flush | (mem_valid_q & (fields_q.excp | fields_q.ertn));

  assign mem_to_id_bus = {
    mem_valid_q,
    fields_q.res_from_mem & ~mem_ready_go,
    fields_q.regw,
    mem_valid_q ? fields_q.regw_addr : 5'd0,
    fields_q.result
  };

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: pass-through, load extraction, WB stall
// buffering, flush cancellation, exception store and asynchronous reset.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic        exe_regW;
  logic [4:0]  exe_regWAddr;
  logic        exe_res_from_mem;
  logic        exe_memW;
  logic [1:0]  exe_memINS_rec;
  logic        exe_load_sign;
  logic        exe_excp;
  logic        exe_ertn;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_to_wb_pc;
  logic [31:0] mem_to_wb_result;
  logic        mem_to_wb_regW;
  logic [4:0]  mem_to_wb_regWAddr;
  logic        mem_to_wb_excp;
  logic        mem_to_wb_ertn;
  logic        wb_flush;
  logic        mem_to_exe_flush_excp_ertn;
  logic [39:0] mem_to_id_bus;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.CANCEL_W(2)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .exe_to_mem_valid           (exe_to_mem_valid),
    .mem_allowin                (mem_allowin),
    .exe_pc                     (exe_pc),
    .exe_result                 (exe_result),
    .exe_regW                   (exe_regW),
    .exe_regWAddr               (exe_regWAddr),
    .exe_res_from_mem           (exe_res_from_mem),
    .exe_memW                   (exe_memW),
    .exe_memINS_rec             (exe_memINS_rec),
    .exe_load_sign              (exe_load_sign),
    .exe_excp                   (exe_excp),
    .exe_ertn                   (exe_ertn),
    .data_sram_data_ok          (data_sram_data_ok),
    .data_sram_rdata            (data_sram_rdata),
    .wb_allowin                 (wb_allowin),
    .mem_to_wb_valid            (mem_to_wb_valid),
    .mem_to_wb_pc               (mem_to_wb_pc),
    .mem_to_wb_result           (mem_to_wb_result),
    .mem_to_wb_regW             (mem_to_wb_regW),
    .mem_to_wb_regWAddr         (mem_to_wb_regWAddr),
    .mem_to_wb_excp             (mem_to_wb_excp),
    .mem_to_wb_ertn             (mem_to_wb_ertn),
    .wb_flush                   (wb_flush),
    .mem_to_exe_flush_excp_ertn (mem_to_exe_flush_excp_ertn),
    .mem_to_id_bus              (mem_to_id_bus)
  );

  task automatic idle_inputs();
    exe_to_mem_valid  = 1'b0;
    exe_pc            = '0;
    exe_result        = '0;
    exe_regW          = 1'b0;
    exe_regWAddr      = '0;
    exe_res_from_mem  = 1'b0;
    exe_memW          = 1'b0;
    exe_memINS_rec    = MEM_W;
    exe_load_sign     = 1'b0;
    exe_excp          = 1'b0;
    exe_ertn          = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    wb_allowin        = 1'b1;
    wb_flush          = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic regw,
                       input logic [4:0] ra, input logic ld, input logic st,
                       input logic [1:0] sz, input logic sgn, input logic ex, input logic er);
    exe_to_mem_valid = 1'b1;
    exe_pc           = pc;
    exe_result       = res;
    exe_regW         = regw;
    exe_regWAddr     = ra;
    exe_res_from_mem = ld;
    exe_memW         = st;
    exe_memINS_rec   = sz;
    exe_load_sign    = sgn;
    exe_excp         = ex;
    exe_ertn         = er;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #3;
    total_cnt++; if (mem_allowin !== 1'b1) $display("FAIL reset_allowin: got %0h exp 1", mem_allowin); else pass_cnt++;
    total_cnt++; if (mem_to_wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %0h exp 0", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_exe_flush_excp_ertn !== 1'b0) $display("FAIL reset_flush: got %0h exp 0", mem_to_exe_flush_excp_ertn); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus !== 40'h0) $display("FAIL reset_id_bus: got %h exp 0", mem_to_id_bus); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'h0) $display("FAIL reset_result: got %h exp 0", mem_to_wb_result); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_alu_pass();
    @(negedge clk);
    issue(32'h0000_0100, 32'h0000_1234, 1'b1, 5'd4, 1'b0, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++; if (mem_allowin !== 1'b1) $display("FAIL alu_allowin_empty: got %0h exp 1", mem_allowin); else pass_cnt++;
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1) $display("FAIL alu_wb_valid: got %0h exp 1", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'h0000_1234) $display("FAIL alu_result: got %h exp 00001234", mem_to_wb_result); else pass_cnt++;
    total_cnt++; if (mem_to_wb_pc !== 32'h0000_0100) $display("FAIL alu_pc: got %h exp 00000100", mem_to_wb_pc); else pass_cnt++;
    total_cnt++; if (mem_to_wb_regW !== 1'b1 || mem_to_wb_regWAddr !== 5'd4) $display("FAIL alu_regw: got %0h/%0d exp 1/4", mem_to_wb_regW, mem_to_wb_regWAddr); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus !== {1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_1234}) $display("FAIL alu_id_bus: got %h exp %h", mem_to_id_bus, {1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_1234}); else pass_cnt++;
    total_cnt++; if (mem_allowin !== 1'b1) $display("FAIL alu_allowin_full: got %0h exp 1", mem_allowin); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b0) $display("FAIL alu_drained: got %0h exp 0", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus[36:32] !== 5'd0) $display("FAIL alu_idbus_addr_invalid: got %0d exp 0", mem_to_id_bus[36:32]); else pass_cnt++;
  endtask

  task automatic test_load_extract();
    // ld.b signed: one wait cycle before data_ok.
    @(negedge clk);
    issue(32'h0000_0200, 32'h1000_0002, 1'b1, 5'd5, 1'b1, 1'b0, MEM_B, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b0) $display("FAIL ldb_waiting_valid: got %0h exp 0", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_allowin !== 1'b0) $display("FAIL ldb_waiting_allowin: got %0h exp 0", mem_allowin); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus[38] !== 1'b1) $display("FAIL ldb_idbus_pending: got %0h exp 1", mem_to_id_bus[38]); else pass_cnt++;
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0080_0000;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1) $display("FAIL ldb_done_valid: got %0h exp 1", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'hFFFF_FF80) $display("FAIL ldb_result: got %h exp ffffff80", mem_to_wb_result); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus[38] !== 1'b0) $display("FAIL ldb_idbus_ready: got %0h exp 0", mem_to_id_bus[38]); else pass_cnt++;
    // ld.hu: data_ok in the very first cycle in MEM.
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    issue(32'h0000_0204, 32'h1000_0002, 1'b1, 5'd6, 1'b1, 1'b0, MEM_H, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1) $display("FAIL ldhu_valid: got %0h exp 1", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'h0000_8001) $display("FAIL ldhu_result: got %h exp 00008001", mem_to_wb_result); else pass_cnt++;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_wb_stall();
    @(negedge clk);
    issue(32'h0000_0300, 32'h0000_2000, 1'b1, 5'd7, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid  = 1'b0;
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    #1;
    total_cnt++; if (mem_allowin !== 1'b0) $display("FAIL stall_allowin: got %0h exp 0", mem_allowin); else pass_cnt++;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    total_cnt++; if (dut.rdata_buf_valid_q !== 1'b1) $display("FAIL stall_buf_valid: got %0h exp 1", dut.rdata_buf_valid_q); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'hCAFE_F00D) $display("FAIL stall_buf_result: got %h exp cafef00d", mem_to_wb_result); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    wb_allowin = 1'b1;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1) $display("FAIL stall_release_valid: got %0h exp 1", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'hCAFE_F00D) $display("FAIL stall_release_result: got %h exp cafef00d", mem_to_wb_result); else pass_cnt++;
    total_cnt++; if (mem_allowin !== 1'b1) $display("FAIL stall_release_allowin: got %0h exp 1", mem_allowin); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b0 || dut.rdata_buf_valid_q !== 1'b0) $display("FAIL stall_drained: got %0h/%0h exp 0/0", mem_to_wb_valid, dut.rdata_buf_valid_q); else pass_cnt++;
  endtask

  task automatic test_cancel();
    @(negedge clk);
    issue(32'h0000_0400, 32'h0000_3000, 1'b1, 5'd8, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    wb_flush         = 1'b1;
    #1;
    total_cnt++; if (mem_to_exe_flush_excp_ertn !== 1'b1) $display("FAIL cancel_flush_out: got %0h exp 1", mem_to_exe_flush_excp_ertn); else pass_cnt++;
    @(negedge clk);
    wb_flush = 1'b0;
    issue(32'h0000_0404, 32'h0000_4000, 1'b1, 5'd9, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++; if (dut.cancel_cnt_q !== 2'd1) $display("FAIL cancel_cnt_inc: got %0d exp 1", dut.cancel_cnt_q); else pass_cnt++;
    total_cnt++; if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1) $display("FAIL cancel_emptied: got valid %0h allowin %0h exp 0/1", mem_to_wb_valid, mem_allowin); else pass_cnt++;
    @(negedge clk);
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b0) $display("FAIL cancel_discard: got %0h exp 0", mem_to_wb_valid); else pass_cnt++;
    @(negedge clk);
    data_sram_rdata = 32'h600D_F00D;
    #1;
    total_cnt++; if (dut.cancel_cnt_q !== 2'd0) $display("FAIL cancel_cnt_dec: got %0d exp 0", dut.cancel_cnt_q); else pass_cnt++;
    total_cnt++; if (mem_to_wb_valid !== 1'b1) $display("FAIL cancel_new_valid: got %0h exp 1", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_wb_result !== 32'h600D_F00D || mem_to_wb_regWAddr !== 5'd9) $display("FAIL cancel_new_result: got %h/%0d exp 600df00d/9", mem_to_wb_result, mem_to_wb_regWAddr); else pass_cnt++;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_with_data_ok();
    @(negedge clk);
    issue(32'h0000_0500, 32'h0000_7000, 1'b1, 5'd10, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid  = 1'b0;
    wb_flush          = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_5555;
    @(negedge clk);
    wb_flush          = 1'b0;
    data_sram_data_ok = 1'b0;
    issue(32'h0000_0504, 32'h0000_7004, 1'b1, 5'd11, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++; if (dut.cancel_cnt_q !== 2'd0) $display("FAIL flushok_no_inc: got %0d exp 0", dut.cancel_cnt_q); else pass_cnt++;
    @(negedge clk);
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_result !== 32'h1234_5678) $display("FAIL flushok_next_load: got %0h/%h exp 1/12345678", mem_to_wb_valid, mem_to_wb_result); else pass_cnt++;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_store_excp();
    @(negedge clk);
    issue(32'h0000_0600, 32'h0000_5000, 1'b1, 5'd3, 1'b0, 1'b1, MEM_W, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    issue(32'h0000_0604, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 1'b0, MEM_W, 1'b0, 1'b0, 1'b1);
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1) $display("FAIL excp_store_valid: got %0h exp 1", mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_to_wb_regW !== 1'b0) $display("FAIL excp_store_regw: got %0h exp 0", mem_to_wb_regW); else pass_cnt++;
    total_cnt++; if (mem_to_wb_excp !== 1'b1) $display("FAIL excp_store_excp: got %0h exp 1", mem_to_wb_excp); else pass_cnt++;
    total_cnt++; if (mem_to_exe_flush_excp_ertn !== 1'b1) $display("FAIL excp_store_flush: got %0h exp 1", mem_to_exe_flush_excp_ertn); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus[38] !== 1'b0) $display("FAIL excp_store_no_wait: got %0h exp 0", mem_to_id_bus[38]); else pass_cnt++;
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    #1;
    total_cnt++; if (mem_to_wb_ertn !== 1'b1 || mem_to_exe_flush_excp_ertn !== 1'b1) $display("FAIL ertn_flush: got %0h/%0h exp 1/1", mem_to_wb_ertn, mem_to_exe_flush_excp_ertn); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (mem_to_exe_flush_excp_ertn !== 1'b0) $display("FAIL ertn_flush_clear: got %0h exp 0", mem_to_exe_flush_excp_ertn); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    issue(32'h0000_0700, 32'h0000_8000, 1'b1, 5'd1, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    wb_flush         = 1'b1;
    @(negedge clk);
    wb_flush = 1'b0;
    issue(32'h0000_0704, 32'h0000_8004, 1'b1, 5'd2, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid = 1'b0;
    #1;
    total_cnt++; if (dut.cancel_cnt_q !== 2'd1 || mem_allowin !== 1'b0) $display("FAIL arst_pre_state: got cnt %0d allowin %0h exp 1/0", dut.cancel_cnt_q, mem_allowin); else pass_cnt++;
    #1;
    resetn = 1'b0;
    #1;
    total_cnt++; if (mem_allowin !== 1'b1) $display("FAIL arst_allowin: got %0h exp 1", mem_allowin); else pass_cnt++;
    total_cnt++; if (mem_to_id_bus !== 40'h0 || mem_to_wb_valid !== 1'b0) $display("FAIL arst_outputs: got %h/%0h exp 0/0", mem_to_id_bus, mem_to_wb_valid); else pass_cnt++;
    total_cnt++; if (dut.cancel_cnt_q !== 2'd0 || dut.rdata_buf_valid_q !== 1'b0) $display("FAIL arst_state: got cnt %0d buf %0h exp 0/0", dut.cancel_cnt_q, dut.rdata_buf_valid_q); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue(32'h0000_0708, 32'h0000_9001, 1'b1, 5'd12, 1'b1, 1'b0, MEM_B, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_AB00;
    #1;
    total_cnt++; if (mem_to_wb_valid !== 1'b1 || mem_to_wb_result !== 32'h0000_00AB) $display("FAIL arst_next_load: got %0h/%h exp 1/000000ab", mem_to_wb_valid, mem_to_wb_result); else pass_cnt++;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_pass();
    test_load_extract();
    test_wb_stall();
    test_cancel();
    test_flush_with_data_ok();
    test_store_excp();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
